// File: rtl/counter_ud_mod.sv
// Parametrised modulo up/down counter with variable step, wrap or saturate
// behaviour, a registered wrap pulse and sticky overflow/underflow flags.
module counter_ud_mod #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              at_max,
  output logic              at_zero,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  if (MAX_VAL > 2**WIDTH - 1 || MAX_VAL == 0) begin : g_bad_max_val
    $error("counter_ud_mod: MAX_VAL must lie in 1..2**WIDTH-1");
  end
  if (2**STEP_W - 1 > MAX_VAL + 1) begin : g_bad_step_w
    $error("counter_ud_mod: largest step exceeds the modulus MAX_VAL+1");
  end

  // Wide enough that count+step and count+modulus never truncate.
  localparam int AW = WIDTH + STEP_W + 1;

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [AW-1:0]    MAX_EXT = AW'(MAX_VAL);
  localparam logic [AW-1:0]    MOD_EXT = AW'(MAX_VAL) + AW'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_set;
  logic             unf_set;
  logic [AW-1:0]    cnt_ext;
  logic [AW-1:0]    step_ext;
  logic [AW-1:0]    sum_ext;

  assign cnt_ext  = AW'(count);
  assign step_ext = AW'(step);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    sum_ext   = '0;
    if (load_en) begin
      count_nxt = (load > MAX_W) ? MAX_W : load;
    end else if (en && (step != '0)) begin
      if (!down) begin
        sum_ext = cnt_ext + step_ext;
        if (sum_ext > MAX_EXT) begin
          ovf_set = 1'b1;
          if (sat_mode) begin
            count_nxt = MAX_W;
          end else begin
            count_nxt = WIDTH'(sum_ext - MOD_EXT);
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = WIDTH'(sum_ext);
        end
      end else begin
        if (step_ext > cnt_ext) begin
          unf_set = 1'b1;
          if (sat_mode) begin
            count_nxt = '0;
          end else begin
            sum_ext   = cnt_ext + MOD_EXT - step_ext;
            count_nxt = WIDTH'(sum_ext);
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = WIDTH'(cnt_ext - step_ext);
        end
      end
    end
  end

  // A set in the same cycle as clr_flags leaves the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap       <= wrap_nxt;
      ovf_sticky <= ovf_set | (ovf_sticky & ~clr_flags);
      unf_sticky <= unf_set | (unf_sticky & ~clr_flags);
    end
  end

  assign at_max  = (count == MAX_W);
  assign at_zero = (count == '0);

endmodule
